// File: rtl/hyst_pkg.sv
// -----------------------------------------------------------------------------
// hyst_pkg
// Shared types and constants for the hysteresis result writer.
//   writer_state_t   : IDLE / LOAD / WRITE states of the column writer
//   HYST_COL_PIXELS  : pixels per hysteresis column (10)
//   PIXEL_W          : bits per pixel (8)
//   hyst_col_t       : one captured column {pix, x, y}
//   byte_lane_en     : one-hot byte enable for a byte address offset
//   replicate_pixel  : pixel byte replicated across a 32-bit word
// -----------------------------------------------------------------------------
package hyst_pkg;

    localparam int unsigned HYST_COL_PIXELS = 10;
    localparam int unsigned PIXEL_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } writer_state_t;

    typedef struct packed {
        logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] pix;
        logic [31:0]                             x;
        logic [31:0]                             y;
    } hyst_col_t;

    function automatic logic [3:0] byte_lane_en(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            2'd3:    be = 4'b1000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_pixel(input logic [PIXEL_W-1:0] p);
        return {4{p}};
    endfunction

endpackage

// File: rtl/hyst_result_writer_if.sv
// -----------------------------------------------------------------------------
// hyst_result_writer_if
// Request/ack byte write port into the output frame buffer.
//   mem_addr    : byte write address
//   mem_wdata   : pixel byte replicated 4x
//   mem_byte_en : one-hot of mem_addr[1:0]
//   mem_write   : write request, held until mem_ack is sampled high
//   mem_ack     : write accepted
// master = writer, slave = memory.
// -----------------------------------------------------------------------------
interface hyst_result_writer_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_write;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_byte_en,
        output mem_write,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_byte_en,
        input  mem_write,
        output mem_ack
    );
endinterface

// File: rtl/hyst_result_fifo.sv
// -----------------------------------------------------------------------------
// hyst_result_fifo
// Synchronous FIFO of captured hysteresis columns.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data (accepted when not full, or when popping)
//   i_pop     : drop the head entry (ignored when empty)
//   i_data    : column to store
//   o_data    : head column (valid when !o_empty)
//   o_full    : count == DEPTH
//   o_empty   : count == 0
//   o_count   : number of stored columns
// -----------------------------------------------------------------------------
module hyst_result_fifo
    import hyst_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  hyst_col_t                    i_data,
    output hyst_col_t                    o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    hyst_col_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/hyst_result_writer.sv
// -----------------------------------------------------------------------------
// hyst_result_writer
// Captures finished hysteresis columns and writes them, one byte per pixel,
// into the frame buffer (row pitch IMG_WIDTH, origin BASE_ADDR).
//   clk, rst     : clock, asynchronous active-high reset
//   hyst_final   : controller filter phase done (rising edge captures a column)
//   hyst_out     : result column, element i = row offset i
//   anchor_x/y   : column x and top-row y
//   hold_anchor  : FIFO full, upstream must not advance the anchor
//   mem          : request/ack frame-buffer write port (master side)
//   busy         : FIFO non-empty or writer not IDLE
//   overflow     : sticky, a capture was dropped
// Optional build macro HYST_WRITER_SKIP_ZERO_EN: zero pixels are skipped
// (no write issued) because the frame buffer is pre-cleared by software.
// -----------------------------------------------------------------------------
module hyst_result_writer
    import hyst_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    hyst_final,
    input  logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] hyst_out,
    input  logic [31:0]                             anchor_x,
    input  logic [31:0]                             anchor_y,
    output logic                                    hold_anchor,
    hyst_result_writer_if.master                    mem,
    output logic                                    busy,
    output logic                                    overflow
);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] PITCH    = 32'(IMG_WIDTH);
    localparam logic [3:0]  LAST_IDX = 4'(HYST_COL_PIXELS - 1);

    writer_state_t                           r_state;
    logic                                    r_final_q;
    logic                                    r_overflow;
    logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] r_pix;
    logic [31:0]                             r_addr;
    logic [3:0]                              r_index;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    hyst_col_t        w_in_col;
    hyst_col_t        w_head;
    logic [31:0]      w_load_addr;
    logic [31:0]      w_next_addr;
    logic [7:0]       w_next_pix;
    logic             w_load_wr;
    logic             w_next_wr;
    logic             w_advance;

    assign w_push   = hyst_final && !r_final_q;
    assign w_pop    = (r_state == LOAD);
    assign w_in_col = '{pix: hyst_out, x: anchor_x, y: anchor_y};

    hyst_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in_col),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The row multiply is only consumed in LOAD; per-pixel steps use the add.
    assign w_load_addr = BASE_ADDR + (w_head.y * PITCH) + w_head.x;
    assign w_next_addr = r_addr + PITCH;

    // Next pixel to present, plus whether each pixel needs a real write.
    always_comb begin
        w_next_pix = 8'd0;
        if (r_index < LAST_IDX) begin
            w_next_pix = r_pix[r_index + 4'd1];
        end else begin
            w_next_pix = 8'd0;
        end
`ifdef HYST_WRITER_SKIP_ZERO_EN
        w_load_wr = (w_head.pix[0] != 8'd0);
        w_next_wr = (w_next_pix != 8'd0);
        // A skipped pixel (no request) advances without waiting for ack.
        w_advance = !mem.mem_write || mem.mem_ack;
`else
        w_load_wr = 1'b1;
        w_next_wr = 1'b1;
        w_advance = mem.mem_write && mem.mem_ack;
`endif
    end

    // Capture edge detection and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_final_q  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_final_q <= hyst_final;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Column writer FSM with registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_pix           <= '0;
            r_addr          <= 32'd0;
            r_index         <= 4'd0;
            mem.mem_write   <= 1'b0;
            mem.mem_addr    <= 32'd0;
            mem.mem_wdata   <= 32'd0;
            mem.mem_byte_en <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    r_pix           <= w_head.pix;
                    r_addr          <= w_load_addr;
                    r_index         <= 4'd0;
                    mem.mem_write   <= w_load_wr;
                    mem.mem_addr    <= w_load_addr;
                    mem.mem_wdata   <= replicate_pixel(w_head.pix[0]);
                    mem.mem_byte_en <= byte_lane_en(w_load_addr[1:0]);
                    r_state         <= WRITE;
                end
                WRITE: begin
                    if (w_advance) begin
                        if (r_index == LAST_IDX) begin
                            mem.mem_write <= 1'b0;
                            r_state       <= w_empty ? IDLE : LOAD;
                        end else begin
                            r_index         <= r_index + 4'd1;
                            r_addr          <= w_next_addr;
                            mem.mem_write   <= w_next_wr;
                            mem.mem_addr    <= w_next_addr;
                            mem.mem_wdata   <= replicate_pixel(w_next_pix);
                            mem.mem_byte_en <= byte_lane_en(w_next_addr[1:0]);
                        end
                    end else begin
                        r_state <= WRITE;
                    end
                end
                default: begin
                    mem.mem_write <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign hold_anchor = (w_count == CNT_W'(FIFO_DEPTH));
    assign busy        = (r_state != IDLE) || (w_count != '0);
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_hyst_result_writer.sv
// -----------------------------------------------------------------------------
// tb_hyst_result_writer
// Directed bench for hyst_result_writer with a write scoreboard. Inputs change
// 1 time unit after the rising edge; the write monitor samples on the falling
// edge, where a request with ack high will be accepted at the next rising edge.
// -----------------------------------------------------------------------------
module tb_hyst_result_writer;
    import hyst_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_wr_t;

    logic                                    clk = 1'b0;
    logic                                    rst;
    logic                                    hyst_final;
    logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] hyst_out;
    logic [31:0]                             anchor_x;
    logic [31:0]                             anchor_y;
    logic                                    hold_anchor;
    logic                                    busy;
    logic                                    overflow;

    hyst_result_writer_if mem_if ();

    hyst_result_writer dut (
        .clk         (clk),
        .rst         (rst),
        .hyst_final  (hyst_final),
        .hyst_out    (hyst_out),
        .anchor_x    (anchor_x),
        .anchor_y    (anchor_y),
        .hold_anchor (hold_anchor),
        .mem         (mem_if.master),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int      n_assert = 0;
    int      n_fail   = 0;
    int      n_writes = 0;
    exp_wr_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted write must match the oldest expected write.
    always @(negedge clk) begin
        exp_wr_t e;
        if (rst === 1'b0 && mem_if.mem_write === 1'b1 && mem_if.mem_ack === 1'b1) begin
            n_writes++;
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr 0x%08h expected no write", mem_if.mem_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_if.mem_addr, e.addr);
                chk("wr_data", mem_if.mem_wdata, e.data);
                chk("wr_be", {28'd0, mem_if.mem_byte_en}, {28'd0, e.be});
            end
        end
    end

    // Reference addressing: direct multiply per pixel, default pitch and origin.
    task automatic model_column(input logic [31:0] x, input logic [31:0] y,
                                input logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] pix);
        exp_wr_t e;
        for (int i = 0; i < 10; i++) begin
            e.addr = y * 32'd640 + x + 32'(i) * 32'd640;
            e.data = {4{pix[i]}};
            e.be   = 4'b0001 << e.addr[1:0];
`ifdef HYST_WRITER_SKIP_ZERO_EN
            if (pix[i] != 8'd0) exp_q.push_back(e);
`else
            exp_q.push_back(e);
`endif
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left 1 unit after a rising edge; the capture edge is inside.
    task automatic capture(input logic [31:0] x, input logic [31:0] y,
                           input logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] pix,
                           input bit kept);
        anchor_x   = x;
        anchor_y   = y;
        hyst_out   = pix;
        hyst_final = 1'b1;
        if (kept) model_column(x, y, pix);
        step(1);
        hyst_final = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [HYST_COL_PIXELS-1:0][PIXEL_W-1:0] pix;
        logic [31:0] a_hold;
        logic [31:0] d_hold;
        int          w0;

        rst            = 1'b1;
        hyst_final     = 1'b0;
        hyst_out       = '0;
        anchor_x       = 32'd0;
        anchor_y       = 32'd0;
        mem_if.mem_ack = 1'b0;
        step(3);
        rst = 1'b0;
        step(3);

        // Reset while idle: everything returns to zero immediately.
        rst = 1'b1;
        #1;
        chk("rst_mem_write", {31'd0, mem_if.mem_write}, 32'd0);
        chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_if.mem_byte_en}, 32'd0);
        chk("rst_hold", {31'd0, hold_anchor}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        step(2);
        rst = 1'b0;
        step(2);

        // Single column, ack tied high, with latency check.
        mem_if.mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) pix[i] = 8'(i + 1);
        w0 = n_writes;
        capture(32'd5, 32'd2, pix, 1'b1);
        chk("lat_e0", {31'd0, mem_if.mem_write}, 32'd0);
        step(1);
        chk("lat_load", {31'd0, mem_if.mem_write}, 32'd0);
        step(1);
        chk("lat_write", {31'd0, mem_if.mem_write}, 32'd1);
        chk("first_addr", mem_if.mem_addr, 32'd1285);
        wait_idle("single_idle", 100);
        chk("single_count", 32'(n_writes - w0), 32'd10);

        // Ack stall on pixel index 4.
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'h10 + i);
        capture(32'd100, 32'd3, pix, 1'b1);
        step(6);
        chk("stall_addr", mem_if.mem_addr, 32'd2020 + 32'd4 * 32'd640);
        mem_if.mem_ack = 1'b0;
        a_hold = mem_if.mem_addr;
        d_hold = mem_if.mem_wdata;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stall_addr_hold", mem_if.mem_addr, a_hold);
            chk("stall_data_hold", mem_if.mem_wdata, d_hold);
            chk("stall_write_hold", {31'd0, mem_if.mem_write}, 32'd1);
        end
        mem_if.mem_ack = 1'b1;
        step(1);
        chk("stall_next_addr", mem_if.mem_addr, a_hold + 32'd640);
        chk("stall_next_data", mem_if.mem_wdata, 32'h15151515);
        wait_idle("stall_idle", 100);

        // Fill the FIFO with ack low, then overflow it.
        mem_if.mem_ack = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'h20 + i);
        capture(32'd1, 32'd10, pix, 1'b1);
        step(3);
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'h40 + i);
        capture(32'd2, 32'd20, pix, 1'b1);
        chk("hold_after_2", {31'd0, hold_anchor}, 32'd0);
        step(1);
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'h60 + i);
        capture(32'd3, 32'd30, pix, 1'b1);
        chk("hold_after_3", {31'd0, hold_anchor}, 32'd1);
        chk("ovf_before_4", {31'd0, overflow}, 32'd0);
        step(1);
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'h80 + i);
        capture(32'd4, 32'd40, pix, 1'b0);
        chk("ovf_after_4", {31'd0, overflow}, 32'd1);
        chk("hold_after_4", {31'd0, hold_anchor}, 32'd1);
        mem_if.mem_ack = 1'b1;
        wait_idle("full_idle", 300);
        chk("full_count", 32'(n_writes - w0), 32'd30);
        chk("full_hold_clr", {31'd0, hold_anchor}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

`ifdef HYST_WRITER_SKIP_ZERO_EN
        // Only the nonzero pixel produces a write.
        pix    = '0;
        pix[7] = 8'hFF;
        w0 = n_writes;
        capture(32'd0, 32'd0, pix, 1'b1);
        wait_idle("skip_idle", 100);
        chk("skip_count", 32'(n_writes - w0), 32'd1);
`endif

        // Reset in the middle of a column: request drops at once, work discarded.
        for (int i = 0; i < 10; i++) pix[i] = 8'(8'hA0 + i);
        capture(32'd7, 32'd1, pix, 1'b1);
        step(7);
        chk("midrst_active", {31'd0, mem_if.mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_write", {31'd0, mem_if.mem_write}, 32'd0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        w0 = n_writes;
        step(20);
        chk("midrst_count", 32'(n_writes - w0), 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ovf_clr", {31'd0, overflow}, 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
